// File: rtl/id_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_pkg
// Description : Shared definitions for the decode stage: opcode encodings,
//               instruction field positions, ID/EX latch record and small
//               helper functions (sign extension, hazard/forward qualifiers).
// Revision    : 1.0 - initial release
// ============================================================================
package id_pkg;

  localparam int NREGS_DEFAULT       = 8;
  localparam int FLUSH_SLOTS_DEFAULT = 2;

  // Instruction field positions
  localparam int OP_HI    = 15;
  localparam int OP_LO    = 12;
  localparam int RD_HI    = 11;
  localparam int RD_LO    = 9;
  localparam int RS_HI    = 8;
  localparam int RS_LO    = 6;
  localparam int RT_HI    = 5;
  localparam int RT_LO    = 3;
  localparam int IMM6_HI  = 5;
  localparam int IMM12_HI = 11;

  // Opcodes
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_LW   = 4'h5;
  localparam logic [3:0] OP_SW   = 4'h6;
  localparam logic [3:0] OP_BEQ  = 4'h7;
  localparam logic [3:0] OP_BNE  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_NOP  = 4'hF;

  // Contents of the ID/EX pipeline latch
  typedef struct packed {
    logic [3:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] imm;
    logic        reg_wr;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] pc;
  } id_ex_t;

  // Empty slot: NOP opcode, every control and data field cleared
  function automatic id_ex_t id_ex_bubble();
    id_ex_t b;
    b    = '0;
    b.op = OP_NOP;
    return b;
  endfunction

  function automatic logic [15:0] sext6(input logic [5:0] v);
    return {{10{v[5]}}, v};
  endfunction

  function automatic logic [15:0] sext12(input logic [11:0] v);
    return {{4{v[11]}}, v};
  endfunction

  // A branch source that is still being produced by a write in EX, or by a
  // load in MEM, cannot be compared yet.
  function automatic logic branch_src_hazard(
    input logic [2:0] src,
    input logic [2:0] ex_rd,
    input logic       ex_reg_wr,
    input logic [2:0] mem_rd,
    input logic       mem_reg_wr,
    input logic       mem_is_load
  );
    return (src != 3'd0) &&
           ((ex_reg_wr && (src == ex_rd)) ||
            (mem_reg_wr && mem_is_load && (src == mem_rd)));
  endfunction

  // A non-load result sitting in MEM is newer than the register file copy
  function automatic logic mem_fwd_hit(
    input logic [2:0] src,
    input logic [2:0] mem_rd,
    input logic       mem_reg_wr,
    input logic       mem_is_load
  );
    return (src != 3'd0) && mem_reg_wr && !mem_is_load && (src == mem_rd);
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_regfile.sv
`default_nettype none
// ============================================================================
// Module      : id_regfile
// Description : NREGS x 16 register file. Two combinational read ports with
//               write-through from the same-cycle write, one synchronous write
//               port. R0 always reads zero and ignores writes.
// Ports       : clk, rst_n        - clock, async active-low reset
//               ra_addr/ra_data   - read port A
//               rb_addr/rb_data   - read port B
//               we/wa/wd          - write port (applied on posedge clk)
// Revision    : 1.0 - initial release
// ============================================================================
module id_regfile
  import id_pkg::*;
#(
  parameter int NREGS = NREGS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  ra_addr,
  output logic [15:0] ra_data,
  input  logic [2:0]  rb_addr,
  output logic [15:0] rb_data,
  input  logic        we,
  input  logic [2:0]  wa,
  input  logic [15:0] wd
);

  logic [15:0] regs_q [NREGS];
  logic [15:0] regs_d [NREGS];

  always_comb begin
    regs_d = regs_q;
    if (we && (wa != 3'd0)) begin
      regs_d[wa] = wd;
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Write-through lets WB and ID share a cycle without an extra bypass stage
  assign ra_data = (ra_addr == 3'd0)           ? 16'h0000 :
                   (we && (wa == ra_addr))     ? wd       : regs_q[ra_addr];
  assign rb_data = (rb_addr == 3'd0)           ? 16'h0000 :
                   (we && (wa == rb_addr))     ? wd       : regs_q[rb_addr];

endmodule
`default_nettype wire

// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_stage
// Description : Decode stage. Decodes id_instr, reads the register file,
//               detects load-use and branch hazards, resolves BEQ/BNE/JMP,
//               squashes the wrong-path fetch slots and registers the ID/EX
//               latch for the execute stage.
// Ports       : CLOCK_50, reset_n                 - clock, async active-low reset
//               id_instr, id_instr_addr           - instruction from fetch
//               wb_we, wb_rd, wb_data             - register write from WB
//               mem_rd, mem_reg_wr, mem_is_load,
//               mem_alu_result                    - EX/MEM destination info
//               BRANCH, STALL, branch_instr_addr  - feedback to fetch (comb.)
//               ex_*                              - registered ID/EX latch
// Revision    : 1.0 - initial release
// ============================================================================
module id_stage
  import id_pkg::*;
#(
  parameter int FLUSH_SLOTS = FLUSH_SLOTS_DEFAULT,
  parameter int NREGS       = NREGS_DEFAULT
) (
  input  logic        CLOCK_50,
  input  logic        reset_n,
  input  logic [15:0] id_instr,
  input  logic [15:0] id_instr_addr,
  input  logic        wb_we,
  input  logic [2:0]  wb_rd,
  input  logic [15:0] wb_data,
  input  logic [2:0]  mem_rd,
  input  logic        mem_reg_wr,
  input  logic        mem_is_load,
  input  logic [15:0] mem_alu_result,
  output logic        BRANCH,
  output logic        STALL,
  output logic [15:0] branch_instr_addr,
  output logic [3:0]  ex_op,
  output logic [2:0]  ex_rd,
  output logic [2:0]  ex_rs,
  output logic [2:0]  ex_rt,
  output logic [15:0] ex_a,
  output logic [15:0] ex_b,
  output logic [15:0] ex_imm,
  output logic        ex_reg_wr,
  output logic        ex_mem_rd,
  output logic        ex_mem_wr,
  output logic [15:0] ex_pc
);

  localparam int CNT_W = (FLUSH_SLOTS < 2) ? 1 : $clog2(FLUSH_SLOTS + 1);

  // Instruction fields
  logic [3:0]  op_f;
  logic [2:0]  rd_f;
  logic [2:0]  rs_f;
  logic [2:0]  rt_f;
  logic [15:0] imm6_sx;
  logic [15:0] imm12_sx;

  assign op_f     = id_instr[OP_HI:OP_LO];
  assign rd_f     = id_instr[RD_HI:RD_LO];
  assign rs_f     = id_instr[RS_HI:RS_LO];
  assign rt_f     = id_instr[RT_HI:RT_LO];
  assign imm6_sx  = sext6(id_instr[IMM6_HI:0]);
  assign imm12_sx = sext12(id_instr[IMM12_HI:0]);

  // Decoded control
  logic [3:0] dec_op;
  logic       uses_rs;
  logic       uses_b;
  logic       b_is_rd;
  logic       dec_reg_wr;
  logic       dec_mem_rd;
  logic       dec_mem_wr;
  logic       is_cond;
  logic       is_jmp;

  always_comb begin
    dec_op     = OP_NOP;
    uses_rs    = 1'b0;
    uses_b     = 1'b0;
    b_is_rd    = 1'b0;
    dec_reg_wr = 1'b0;
    dec_mem_rd = 1'b0;
    dec_mem_wr = 1'b0;
    is_cond    = 1'b0;
    is_jmp     = 1'b0;
    case (op_f)
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        dec_op     = op_f;
        uses_rs    = 1'b1;
        uses_b     = 1'b1;
        dec_reg_wr = 1'b1;
      end
      OP_ADDI: begin
        dec_op     = op_f;
        uses_rs    = 1'b1;
        dec_reg_wr = 1'b1;
      end
      OP_LW: begin
        dec_op     = op_f;
        uses_rs    = 1'b1;
        dec_reg_wr = 1'b1;
        dec_mem_rd = 1'b1;
      end
      // Store data and the second compare operand live in the rd field,
      // since rt overlaps the imm6 offset.
      OP_SW: begin
        dec_op     = op_f;
        uses_rs    = 1'b1;
        uses_b     = 1'b1;
        b_is_rd    = 1'b1;
        dec_mem_wr = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        dec_op  = op_f;
        uses_rs = 1'b1;
        uses_b  = 1'b1;
        b_is_rd = 1'b1;
        is_cond = 1'b1;
      end
      OP_JMP: begin
        dec_op = op_f;
        is_jmp = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Register file
  logic [2:0]  rb_addr;
  logic [15:0] rf_a;
  logic [15:0] rf_b;

  assign rb_addr = b_is_rd ? rd_f : rt_f;

  id_regfile #(
    .NREGS (NREGS)
  ) u_regfile (
    .clk     (CLOCK_50),
    .rst_n   (reset_n),
    .ra_addr (rs_f),
    .ra_data (rf_a),
    .rb_addr (rb_addr),
    .rb_data (rf_b),
    .we      (wb_we),
    .wa      (wb_rd),
    .wd      (wb_data)
  );

  // State
  id_ex_t             idex_q;
  id_ex_t             idex_d;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_d;

  // Hazards, branch resolution, next-state
  logic        squashing;
  logic        load_use;
  logic        br_hazard;
  logic        stall_c;
  logic        taken;
  logic        branch_c;
  logic [15:0] cmp_a;
  logic [15:0] cmp_b;
  logic [15:0] target;

  always_comb begin
    squashing = (count_q != '0);

    load_use = idex_q.mem_rd && (idex_q.rd != 3'd0) &&
               ((uses_rs && (rs_f == idex_q.rd)) ||
                (uses_b  && (rb_addr == idex_q.rd)));

    br_hazard = is_cond &&
                (branch_src_hazard(rs_f, idex_q.rd, idex_q.reg_wr,
                                   mem_rd, mem_reg_wr, mem_is_load) ||
                 branch_src_hazard(rb_addr, idex_q.rd, idex_q.reg_wr,
                                   mem_rd, mem_reg_wr, mem_is_load));

    // A squashed slot is a NOP, so it can neither stall nor branch
    stall_c = !squashing && (load_use || br_hazard);

    cmp_a = mem_fwd_hit(rs_f, mem_rd, mem_reg_wr, mem_is_load) ? mem_alu_result : rf_a;
    cmp_b = mem_fwd_hit(rb_addr, mem_rd, mem_reg_wr, mem_is_load) ? mem_alu_result : rf_b;

    taken = is_jmp ||
            (is_cond && ((op_f == OP_BEQ) ? (cmp_a == cmp_b) : (cmp_a != cmp_b)));
    branch_c = !squashing && !stall_c && taken;

    target = id_instr_addr + 16'd1 + (is_jmp ? imm12_sx : imm6_sx);

    count_d = count_q;
    if (branch_c) begin
      count_d = CNT_W'(FLUSH_SLOTS);
    end else if (squashing) begin
      count_d = count_q - CNT_W'(1);
    end

    idex_d = id_ex_bubble();
    if (!squashing && !stall_c && (dec_op != OP_NOP)) begin
      idex_d.op     = dec_op;
      idex_d.rd     = rd_f;
      idex_d.rs     = rs_f;
      idex_d.rt     = rt_f;
      idex_d.a      = rf_a;
      idex_d.b      = rf_b;
      idex_d.imm    = imm6_sx;
      idex_d.reg_wr = dec_reg_wr;
      idex_d.mem_rd = dec_mem_rd;
      idex_d.mem_wr = dec_mem_wr;
      idex_d.pc     = id_instr_addr;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      idex_q  <= id_ex_bubble();
      count_q <= '0;
    end else begin
      idex_q  <= idex_d;
      count_q <= count_d;
    end
  end

  // Fetch feedback is forced quiet while reset is held, independent of the
  // instruction currently presented.
  assign BRANCH            = reset_n & branch_c;
  assign STALL             = reset_n & stall_c;
  assign branch_instr_addr = target;

  assign ex_op     = idex_q.op;
  assign ex_rd     = idex_q.rd;
  assign ex_rs     = idex_q.rs;
  assign ex_rt     = idex_q.rt;
  assign ex_a      = idex_q.a;
  assign ex_b      = idex_q.b;
  assign ex_imm    = idex_q.imm;
  assign ex_reg_wr = idex_q.reg_wr;
  assign ex_mem_rd = idex_q.mem_rd;
  assign ex_mem_wr = idex_q.mem_wr;
  assign ex_pc     = idex_q.pc;

endmodule
`default_nettype wire
